// File: rtl/mire_pkg.sv
// rtl/mire_pkg.sv - shared types and constants for the mire_gen pattern generator
// Holds the pattern-mode enum, the master FSM state enum and the colour-bar palette.
package mire_pkg;

  typedef enum logic [1:0] {
    MODE_GRID  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Colour bars, left to right, as 0xRRGGBB.
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

endpackage

// File: rtl/mire_pattern.sv
// rtl/mire_pattern.sv - combinational pixel colour generator
// Ports:
//   mode_i      latched pattern mode
//   pixel_i     current pixel within the line
//   line_i      current line within the frame
//   frame_cnt_i completed-frame count, scrolls the checkerboard
//   data_o      pixel word 0x00RRGGBB
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int GRID  = 16,
  parameter int PW    = $clog2(HDISP),
  parameter int LW    = $clog2(VDISP)
) (
  input  mode_e           mode_i,
  input  logic [PW-1:0]   pixel_i,
  input  logic [LW-1:0]   line_i,
  input  logic [15:0]     frame_cnt_i,
  output logic [31:0]     data_o
);

  logic [31:0] pix32;
  logic [31:0] line32;
  logic [15:0] chk_sum;
  logic [2:0]  bar_idx;
  logic [7:0]  grey;
  logic        grid_on;
  logic        chk_on;
  logic [23:0] rgb;

  assign pix32  = 32'(pixel_i);
  assign line32 = 32'(line_i);

  // Checker phase sum wraps in 16 bits so the scroll follows frame_cnt wrap.
  assign chk_sum = 16'(pixel_i) + frame_cnt_i;

  assign bar_idx = 3'((pix32 * 32'd8) / 32'(HDISP));
  assign grey    = 8'((pix32 * 32'd256) / 32'(HDISP));
  assign grid_on = ((pix32 % 32'(GRID)) == 32'd0) || ((line32 % 32'(GRID)) == 32'd0);
  assign chk_on  = (((32'(chk_sum) / 32'(GRID)) ^ (line32 / 32'(GRID))) & 32'd1) != 32'd0;

  always_comb begin
    rgb = BAR_BLACK;
    case (mode_i)
      MODE_GRID:  rgb = grid_on ? BAR_WHITE : BAR_BLACK;
      MODE_BARS: begin
        case (bar_idx)
          3'd0:    rgb = BAR_WHITE;
          3'd1:    rgb = BAR_YELLOW;
          3'd2:    rgb = BAR_CYAN;
          3'd3:    rgb = BAR_GREEN;
          3'd4:    rgb = BAR_MAGENTA;
          3'd5:    rgb = BAR_RED;
          3'd6:    rgb = BAR_BLUE;
          default: rgb = BAR_BLACK;
        endcase
      end
      MODE_GRAD:  rgb = {grey, grey, grey};
      MODE_CHECK: rgb = chk_on ? BAR_WHITE : BAR_BLACK;
      default:    rgb = BAR_BLACK;
    endcase
  end

  assign data_o = {8'h00, rgb};

endmodule

// File: rtl/mire_gen.sv
// rtl/mire_gen.sv - Wishbone-master test-pattern frame writer
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable, mode        run request and pattern select, sampled at frame start
//   wshb_*              classic Wishbone write master (we/sel/cti/bte constant)
//   wshb_ack            slave acknowledge
//   frame_done          one-cycle pulse in the pause following the last pixel ack
//   frame_cnt           completed-frame counter
module mire_gen
  import mire_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          BURST      = 64,
  parameter int          GRID       = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  input  logic        wshb_ack,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(HDISP);
  localparam int LW = $clog2(VDISP);
  localparam int BW = $clog2(BURST + 1);

  localparam logic [PW-1:0] PIX_LAST   = PW'(HDISP - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(VDISP - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [LW-1:0] line_q, line_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  mode_e         mode_q, mode_d;
  // Set when the pause was entered by the final pixel of the frame.
  logic          last_q, last_d;
  logic          last_pix;
  logic          cyc;

  assign last_pix = (pixel_q == PIX_LAST) && (line_q == LINE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pixel_q     <= '0;
      line_q      <= '0;
      burst_q     <= '0;
      frame_cnt_q <= '0;
      mode_q      <= MODE_GRID;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_q     <= pixel_d;
      line_q      <= line_d;
      burst_q     <= burst_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pixel_d     = pixel_q;
    line_d      = line_q;
    burst_d     = burst_q;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    last_d      = last_q;
    cyc         = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          mode_d  = mode_e'(mode);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cyc = 1'b1;
        if (wshb_ack) begin
          if (pixel_q == PIX_LAST) begin
            pixel_d = '0;
            line_d  = (line_q == LINE_LAST) ? '0 : line_q + LW'(1);
          end else begin
            pixel_d = pixel_q + PW'(1);
          end
          burst_d = burst_q + BW'(1);
          if ((burst_q == BURST_LAST) || last_pix) begin
            state_d = ST_PAUSE;
            burst_d = '0;
            last_d  = last_pix;
          end
        end
      end
      ST_PAUSE: begin
        // One idle cycle gives the video reader a chance to win the bus.
        state_d = ST_REQ;
        if (last_q) begin
          frame_done  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          last_d      = 1'b0;
          if (enable) begin
            mode_d = mode_e'(mode);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wshb_cyc  = cyc;
  assign wshb_stb  = cyc;
  assign wshb_we   = 1'b1;
  assign wshb_sel  = 4'b1111;
  assign wshb_cti  = 3'b000;
  assign wshb_bte  = 2'b00;
  assign frame_cnt = frame_cnt_q;

  assign wshb_adr = BASE_ADDR
                  + ((32'(line_q) * 32'(HDISP)) + 32'(pixel_q)) * 32'(DATA_BYTES);

  mire_pattern #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID),
    .PW    (PW),
    .LW    (LW)
  ) u_pattern (
    .mode_i      (mode_q),
    .pixel_i     (pixel_q),
    .line_i      (line_q),
    .frame_cnt_i (frame_cnt_q),
    .data_o      (wshb_dat_ms)
  );

endmodule

// File: tb/tb_mire_gen.sv
// tb/tb_mire_gen.sv - scoreboard testbench for mire_gen
module tb_mire_gen;

  localparam int          HD    = 32;
  localparam int          VD    = 4;
  localparam int          BU    = 8;
  localparam int          GR    = 4;
  localparam logic [31:0] BA    = 32'h1000;
  localparam int          FRAME = HD * VD;
  localparam int          LIMIT = 5000;

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic [31:0] wshb_adr, wshb_dat_ms;
  logic        wshb_ack = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  mire_gen #(
    .HDISP(HD), .VDISP(VD), .BURST(BU), .GRID(GR), .BASE_ADDR(BA), .DATA_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we), .wshb_sel(wshb_sel),
    .wshb_cti(wshb_cti), .wshb_bte(wshb_bte), .wshb_adr(wshb_adr),
    .wshb_dat_ms(wshb_dat_ms), .wshb_ack(wshb_ack),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int frames_pushed = 0;
  int exp_frames = 0;
  int ack_mode = 0;
  int stall_left = 0;

  bit          mon_on = 1'b0;
  int          frame_pos = 0;
  int          tenure_acks = 0;
  int          tenure_start = 0;
  int          low_run = 0;
  bit          prev_cyc = 1'b0;
  bit          held_valid = 1'b0;
  bit          fd_due = 1'b0;
  bit          fc_due = 1'b0;
  logic [31:0] held_adr, held_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_pixel(int m, int p, int l, int fc);
    logic [7:0] g;
    int c;
    case (m)
      0: return ((p % GR == 0) || (l % GR == 0)) ? 32'h00FFFFFF : 32'h0;
      1: return {8'h00, BAR_TAB[(p * 8) / HD]};
      2: begin
        g = 8'(((p * 256) / HD) % 256);
        return {8'h00, g, g, g};
      end
      default: begin
        c = ((((p + fc) % 65536) / GR) ^ (l / GR)) % 2;
        return (c == 1) ? 32'h00FFFFFF : 32'h0;
      end
    endcase
  endfunction

  task automatic push_frame(input int m);
    exp_t e;
    for (int l = 0; l < VD; l++) begin
      for (int p = 0; p < HD; p++) begin
        e.adr = BA + 32'((l * HD + p) * 4);
        e.dat = ref_pixel(m, p, l, frames_pushed % 65536);
        sb.push_back(e);
      end
    end
    frames_pushed++;
  endtask

  task automatic mon_clear();
    sb.delete();
    frames_pushed = 0;
    exp_frames = 0;
    frame_pos = 0;
    tenure_acks = 0;
    tenure_start = 0;
    low_run = 0;
    prev_cyc = 1'b0;
    held_valid = 1'b0;
    fd_due = 1'b0;
    fc_due = 1'b0;
  endtask

  // Ack driver: 0 = always high, 1 = random 0-3 cycle stalls plus acks forced
  // whenever the bus is released, 2 = never.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: wshb_ack = 1'b1;
        1: begin
          if (!wshb_cyc) begin
            wshb_ack = 1'b1;
          end else if (stall_left > 0) begin
            wshb_ack = 1'b0;
            stall_left--;
          end else begin
            wshb_ack = 1'b1;
            stall_left = $urandom_range(0, 3);
          end
        end
        default: wshb_ack = 1'b0;
      endcase
    end
  end

  task automatic mon_step();
    exp_t e;
    int exp_len;
    if (fc_due) begin
      check("frame_cnt", {16'h0, frame_cnt}, 32'(exp_frames % 65536));
      fc_due = 1'b0;
    end
    if (fd_due) begin
      check("frame_done", {31'h0, frame_done}, 32'd1);
      fd_due = 1'b0;
      fc_due = frame_done;
    end else if (frame_done) begin
      check("frame_done_spurious", {31'h0, frame_done}, 32'd0);
    end
    if (wshb_cyc) begin
      if (!prev_cyc) begin
        if (frame_pos != 0) check("pause_len", 32'(low_run), 32'd1);
        tenure_acks = 0;
        tenure_start = frame_pos;
      end
      low_run = 0;
      if (wshb_stb && wshb_ack) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL transfer: unexpected adr %h dat %h", wshb_adr, wshb_dat_ms);
        end else begin
          e = sb.pop_front();
          check("adr", wshb_adr, e.adr);
          check("dat", wshb_dat_ms, e.dat);
        end
        tenure_acks++;
        frame_pos++;
        held_valid = 1'b0;
        if (frame_pos == FRAME) begin
          frame_pos = 0;
          exp_frames++;
          fd_due = 1'b1;
        end
      end else if (wshb_stb) begin
        if (held_valid) begin
          check("adr_hold", wshb_adr, held_adr);
          check("dat_hold", wshb_dat_ms, held_dat);
        end
        held_valid = 1'b1;
        held_adr = wshb_adr;
        held_dat = wshb_dat_ms;
      end
    end else begin
      if (prev_cyc) begin
        exp_len = (FRAME - tenure_start < BU) ? FRAME - tenure_start : BU;
        check("burst_len", 32'(tenure_acks), 32'(exp_len));
      end
      low_run++;
      held_valid = 1'b0;
    end
    prev_cyc = wshb_cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_on) mon_step();
    end
  end

  task automatic wait_sb_below(input int n, input string what);
    int t = 0;
    while (sb.size() >= n && t < LIMIT) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (t >= LIMIT) begin
      bad++;
      $display("FAIL timeout_%s: queue still %0d, need below %0d", what, sb.size(), n);
    end
    #2;
  endtask

  task automatic run_frames(input int m, input int n);
    mode = 2'(m);
    enable = 1'b1;
    repeat (n) push_frame(m);
    wait_sb_below(FRAME, "last_frame");
    enable = 1'b0;
    wait_sb_below(1, "drain");
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    int hi_cnt;
    int t;
    int new_m;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_cyc", {31'h0, wshb_cyc}, 32'd0);
    check("rst_stb", {31'h0, wshb_stb}, 32'd0);
    check("rst_frame_done", {31'h0, frame_done}, 32'd0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    check("const_bus", {22'h0, wshb_we, wshb_sel, wshb_cti, wshb_bte}, {22'h0, 1'b1, 4'hF, 3'b000, 2'b00});
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(posedge clk);
    #2;

    // Grid, then bars, ack every cycle.
    ack_mode = 0;
    run_frames(0, 1);
    run_frames(1, 1);

    // Gradient with random stalls and acks injected while the bus is idle.
    ack_mode = 1;
    run_frames(2, 2);

    // Scrolling checker over two frames.
    ack_mode = 0;
    run_frames(3, 2);

    // Drop enable and scramble mode mid-frame: the frame finishes as grid.
    mode = 2'd0;
    enable = 1'b1;
    push_frame(0);
    wait_sb_below(FRAME - 10, "t5_start");
    enable = 1'b0;
    mode = 2'd1;
    wait_sb_below(FRAME / 2, "t5_mid");
    mode = 2'($urandom_range(0, 3));
    wait_sb_below(1, "t5_drain");
    hi_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (wshb_cyc) hi_cnt++;
    end
    check("idle_cyc", 32'(hi_cnt), 32'd0);
    new_m = $urandom_range(1, 3);
    run_frames(new_m, 1);

    // Reset asserted while a transfer is stalled.
    ack_mode = 2;
    mode = 2'd0;
    enable = 1'b1;
    t = 0;
    while (!wshb_cyc && t < 20) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("t6_cyc_up", {31'h0, wshb_cyc}, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_cyc", {31'h0, wshb_cyc}, 32'd0);
    check("async_stb", {31'h0, wshb_stb}, 32'd0);
    mon_clear();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("t6_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    ack_mode = 0;
    run_frames(3, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
